// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline's Fetch/Memory requesters, the arbiter and the
// shared single-ported memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              IReqF;
    logic [ADDR_W-1:0] PCF;
    logic              AbortF;
    logic [DATA_W-1:0] InstrF;
    logic              IReadyF;

    logic              DReqM;
    logic              DWeM;
    logic [ADDR_W-1:0] ALUResultM;
    logic [DATA_W-1:0] WriteDataM;
    logic [DATA_W-1:0] ReadDataM;
    logic              DReadyM;

    logic              StallF;
    logic              StallMem;

    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;

    modport slave (
        input  IReqF, PCF, AbortF, DReqM, DWeM, ALUResultM, WriteDataM, MemRData,
        output InstrF, IReadyF, ReadDataM, DReadyM, StallF, StallMem,
               MemReq, MemWe, MemAddr, MemWData
    );

    modport master (
        output IReqF, PCF, AbortF, DReqM, DWeM, ALUResultM, WriteDataM, MemRData,
        input  InstrF, IReadyF, ReadDataM, DReadyM, StallF, StallMem,
               MemReq, MemWe, MemAddr, MemWData
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Grants the single memory port to Fetch or Memory stage one access at a time,
// tracks the fixed read latency and raises the matching ready/stall signals.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int              CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t            state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic              abortQ, abortNext;
    logic              storeQ, storeNext;
    logic              grantD, grantI, done, fetchKilled;
    logic [ADDR_W-1:0] addrSel;
    logic [DATA_W-1:0] wdataSel;

    // Grants are suppressed while reset is held so memory never sees an untracked strobe.
    always_comb begin
        grantD      = (state == IDLE) && !reset && bus.DReqM;
        grantI      = (state == IDLE) && !reset && !bus.DReqM && bus.IReqF && !bus.AbortF;
        done        = (state != IDLE) && (cnt == CNT_ONE);
        fetchKilled = abortQ || bus.AbortF;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            abortQ <= 1'b0;
            storeQ <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            abortQ <= abortNext;
            storeQ <= storeNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        abortNext = abortQ;
        storeNext = storeQ;
        case (state)
            IDLE: begin
                abortNext = 1'b0;
                if (grantD) begin
                    stateNext = DBUSY;
                    cntNext   = LAT_LOAD;
                    storeNext = bus.DWeM;
                end else if (grantI) begin
                    stateNext = IBUSY;
                    cntNext   = LAT_LOAD;
                    storeNext = 1'b0;
                end
            end
            IBUSY: begin
                cntNext = cnt - CNT_ONE;
                if (done) begin
                    stateNext = IDLE;
                    abortNext = 1'b0;
                end else begin
                    abortNext = fetchKilled;
                end
            end
            DBUSY: begin
                cntNext = cnt - CNT_ONE;
                if (done) stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
                abortNext = 1'b0;
                storeNext = 1'b0;
            end
        endcase
    end

    always_comb begin
        addrSel  = '0;
        wdataSel = '0;
        if (grantD) begin
            addrSel  = bus.ALUResultM;
            wdataSel = bus.WriteDataM;
        end else if (grantI) begin
            addrSel  = bus.PCF;
        end

        bus.MemReq   = grantD || grantI;
        bus.MemWe    = grantD && bus.DWeM;
        bus.MemAddr  = addrSel;
        bus.MemWData = wdataSel;

        bus.DReadyM   = done && (state == DBUSY) && !reset;
        bus.ReadDataM = (bus.DReadyM && !storeQ) ? bus.MemRData : '0;

        // An aborted fetch still drains the memory response but never signals ready.
        bus.IReadyF = done && (state == IBUSY) && !fetchKilled && !reset;
        bus.InstrF  = bus.IReadyF ? bus.MemRData : '0;

        bus.StallF   = bus.IReqF && !bus.IReadyF;
        bus.StallMem = bus.DReqM && !bus.DReadyM;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: directed requester sequences push expected grants, readies and
// stall values; a negedge monitor pops and compares them against the DUT.
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: word array preloaded to 0xC0DE0000|addr; data returns LAT cycles after MemReq.
    logic [31:0] mem [1024];
    logic [31:0] rdPipe [LAT];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | (i * 4);
        end else if (bus.MemReq && bus.MemWe) begin
            mem[bus.MemAddr[11:2]] <= bus.MemWData;
        end
        rdPipe[0] <= bus.MemReq ? mem[bus.MemAddr[11:2]] : 32'hBAD0_0BAD;
        for (int i = 1; i < LAT; i++) rdPipe[i] <= rdPipe[i-1];
    end
    assign bus.MemRData = rdPipe[LAT-1];

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
    } ev_t;

    ev_t gq[$];
    ev_t iq[$];
    ev_t dq[$];
    ev_t sq[$];
    int  nCmp = 0;
    int  nBad = 0;
    bit  monOn = 1'b0;

    task automatic chk(input string name, input bit ok, input string act, input string req);
        nCmp++;
        if (!ok) begin
            nBad++;
            $display("FAIL %s @cyc %0d: got %s, want %s", name, cyc, act, req);
        end
    endtask

    task automatic expGrant(input int c, input logic [31:0] a, input logic we, input logic [31:0] d);
        gq.push_back('{cyc: c, a: a, d: d, we: we});
    endtask
    task automatic expI(input int c, input logic [31:0] d);
        iq.push_back('{cyc: c, a: 32'h0, d: d, we: 1'b0});
    endtask
    task automatic expD(input int c, input logic [31:0] d);
        dq.push_back('{cyc: c, a: 32'h0, d: d, we: 1'b0});
    endtask
    task automatic expStall(input int c, input logic f, input logic m);
        sq.push_back('{cyc: c, a: {31'h0, f}, d: {31'h0, m}, we: 1'b0});
    endtask

    always @(negedge clk) begin
        if (monOn) begin
            ev_t e;
            while (gq.size() > 0 && gq[0].cyc < cyc) begin
                e = gq.pop_front();
                chk("grant_missing", 1'b0, "no MemReq", $sformatf("grant c%0d a%h", e.cyc, e.a));
            end
            while (iq.size() > 0 && iq[0].cyc < cyc) begin
                e = iq.pop_front();
                chk("iready_missing", 1'b0, "no IReadyF", $sformatf("IReadyF c%0d", e.cyc));
            end
            while (dq.size() > 0 && dq[0].cyc < cyc) begin
                e = dq.pop_front();
                chk("dready_missing", 1'b0, "no DReadyM", $sformatf("DReadyM c%0d", e.cyc));
            end

            if (bus.MemReq) begin
                if (gq.size() == 0) begin
                    chk("grant_unexpected", 1'b0, $sformatf("MemReq a%h", bus.MemAddr), "no grant");
                end else begin
                    e = gq.pop_front();
                    chk("grant", e.cyc == cyc && bus.MemAddr == e.a && bus.MemWe == e.we && bus.MemWData == e.d,
                        $sformatf("c%0d a%h we%0b d%h", cyc, bus.MemAddr, bus.MemWe, bus.MemWData),
                        $sformatf("c%0d a%h we%0b d%h", e.cyc, e.a, e.we, e.d));
                end
            end else begin
                chk("bus_idle", bus.MemWe == 1'b0 && bus.MemAddr == '0 && bus.MemWData == '0,
                    $sformatf("we%0b a%h d%h", bus.MemWe, bus.MemAddr, bus.MemWData), "all zero");
            end

            if (bus.IReadyF) begin
                if (iq.size() == 0) begin
                    chk("iready_unexpected", 1'b0, $sformatf("InstrF %h", bus.InstrF), "no IReadyF");
                end else begin
                    e = iq.pop_front();
                    chk("instr", e.cyc == cyc && bus.InstrF == e.d,
                        $sformatf("c%0d %h", cyc, bus.InstrF), $sformatf("c%0d %h", e.cyc, e.d));
                end
            end else begin
                chk("instr_idle", bus.InstrF == '0, $sformatf("%h", bus.InstrF), "0");
            end

            if (bus.DReadyM) begin
                if (dq.size() == 0) begin
                    chk("dready_unexpected", 1'b0, $sformatf("ReadDataM %h", bus.ReadDataM), "no DReadyM");
                end else begin
                    e = dq.pop_front();
                    chk("rdata", e.cyc == cyc && bus.ReadDataM == e.d,
                        $sformatf("c%0d %h", cyc, bus.ReadDataM), $sformatf("c%0d %h", e.cyc, e.d));
                end
            end else begin
                chk("rdata_idle", bus.ReadDataM == '0, $sformatf("%h", bus.ReadDataM), "0");
            end

            while (sq.size() > 0 && sq[0].cyc <= cyc) begin
                e = sq.pop_front();
                chk("stall", e.cyc == cyc && bus.StallF == e.a[0] && bus.StallMem == e.d[0],
                    $sformatf("c%0d F%0b M%0b", cyc, bus.StallF, bus.StallMem),
                    $sformatf("c%0d F%0b M%0b", e.cyc, e.a[0], e.d[0]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idleIn();
        bus.IReqF      = 1'b0;
        bus.PCF        = '0;
        bus.AbortF     = 1'b0;
        bus.DReqM      = 1'b0;
        bus.DWeM       = 1'b0;
        bus.ALUResultM = '0;
        bus.WriteDataM = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want normal end");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        idleIn();
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        monOn = 1'b1;
        expStall(cyc, 1'b0, 1'b0);
        step(2);

        // Fetch only, back-to-back
        t0 = cyc;
        bus.IReqF = 1'b1; bus.PCF = 32'h0;
        expGrant(t0, 32'h0, 1'b0, 32'h0);
        expStall(t0, 1'b1, 1'b0); expStall(t0 + 1, 1'b1, 1'b0);
        expI(t0 + 2, 32'hC0DE_0000); expStall(t0 + 2, 1'b0, 1'b0);
        step(3);
        bus.PCF = 32'h4;
        expGrant(t0 + 3, 32'h4, 1'b0, 32'h0);
        expI(t0 + 5, 32'hC0DE_0004);
        step(3);
        idleIn();
        step(2);

        // Simultaneous fetch and load: data wins
        t0 = cyc;
        bus.IReqF = 1'b1; bus.PCF = 32'h8;
        bus.DReqM = 1'b1; bus.ALUResultM = 32'h100;
        expGrant(t0, 32'h100, 1'b0, 32'h0);
        expStall(t0, 1'b1, 1'b1);
        expD(t0 + 2, 32'hC0DE_0100); expStall(t0 + 2, 1'b1, 1'b0);
        step(3);
        bus.DReqM = 1'b0; bus.ALUResultM = '0;
        expGrant(t0 + 3, 32'h8, 1'b0, 32'h0);
        expStall(t0 + 4, 1'b1, 1'b0);
        expI(t0 + 5, 32'hC0DE_0008); expStall(t0 + 5, 1'b0, 1'b0);
        step(3);
        idleIn();
        step(2);

        // Load arrives during an in-flight fetch, then a pending fetch waits behind it
        t0 = cyc;
        bus.IReqF = 1'b1; bus.PCF = 32'h4;
        expGrant(t0, 32'h4, 1'b0, 32'h0);
        step(1);
        bus.DReqM = 1'b1; bus.ALUResultM = 32'h40;
        expStall(t0 + 1, 1'b1, 1'b1);
        expI(t0 + 2, 32'hC0DE_0004); expStall(t0 + 2, 1'b0, 1'b1);
        step(2);
        bus.PCF = 32'h8;
        expGrant(t0 + 3, 32'h40, 1'b0, 32'h0);
        expStall(t0 + 3, 1'b1, 1'b1); expStall(t0 + 4, 1'b1, 1'b1);
        expD(t0 + 5, 32'hC0DE_0040); expStall(t0 + 5, 1'b1, 1'b0);
        step(3);
        bus.DReqM = 1'b0; bus.ALUResultM = '0;
        expGrant(t0 + 6, 32'h8, 1'b0, 32'h0);
        expI(t0 + 8, 32'hC0DE_0008);
        step(3);
        idleIn();
        step(2);

        // Store then load of the same address
        t0 = cyc;
        bus.DReqM = 1'b1; bus.DWeM = 1'b1; bus.ALUResultM = 32'h200; bus.WriteDataM = 32'hDEAD_BEEF;
        expGrant(t0, 32'h200, 1'b1, 32'hDEAD_BEEF);
        expStall(t0 + 1, 1'b0, 1'b1);
        expD(t0 + 2, 32'h0); expStall(t0 + 2, 1'b0, 1'b0);
        step(3);
        bus.DWeM = 1'b0; bus.WriteDataM = '0;
        expGrant(t0 + 3, 32'h200, 1'b0, 32'h0);
        expD(t0 + 5, 32'hDEAD_BEEF);
        step(3);
        idleIn();
        step(2);

        // Abort in the middle of a fetch, redirect to 0x40
        t0 = cyc;
        bus.IReqF = 1'b1; bus.PCF = 32'h8;
        expGrant(t0, 32'h8, 1'b0, 32'h0);
        step(1);
        bus.AbortF = 1'b1; bus.PCF = 32'h40;
        step(1);
        bus.AbortF = 1'b0;
        expStall(t0 + 2, 1'b1, 1'b0);
        step(1);
        expGrant(t0 + 3, 32'h40, 1'b0, 32'h0);
        expI(t0 + 5, 32'hC0DE_0040);
        step(3);
        idleIn();
        step(2);

        // Abort in the completion cycle, then abort held in IDLE blocks one grant
        t0 = cyc;
        bus.IReqF = 1'b1; bus.PCF = 32'h0;
        expGrant(t0, 32'h0, 1'b0, 32'h0);
        step(2);
        bus.AbortF = 1'b1; bus.PCF = 32'h4;
        expStall(t0 + 2, 1'b1, 1'b0);
        step(1);
        expStall(t0 + 3, 1'b1, 1'b0);
        step(1);
        bus.AbortF = 1'b0;
        expGrant(t0 + 4, 32'h4, 1'b0, 32'h0);
        expI(t0 + 6, 32'hC0DE_0004);
        step(3);
        idleIn();
        step(2);

        // Reset in the middle of a load; stale return must not produce a ready
        t0 = cyc;
        bus.DReqM = 1'b1; bus.ALUResultM = 32'h100;
        expGrant(t0, 32'h100, 1'b0, 32'h0);
        step(1);
        reset = 1'b1;
        expStall(t0 + 1, 1'b0, 1'b1);
        step(1);
        reset = 1'b0;
        expGrant(t0 + 2, 32'h100, 1'b0, 32'h0);
        expStall(t0 + 2, 1'b0, 1'b1);
        expD(t0 + 4, 32'hC0DE_0100);
        step(3);
        idleIn();
        step(3);

        monOn = 1'b0;
        while (gq.size() > 0) begin
            chk("grant_leftover", 1'b0, "none", $sformatf("grant c%0d", gq[0].cyc));
            void'(gq.pop_front());
        end
        while (iq.size() > 0) begin
            chk("iready_leftover", 1'b0, "none", $sformatf("IReadyF c%0d", iq[0].cyc));
            void'(iq.pop_front());
        end
        while (dq.size() > 0) begin
            chk("dready_leftover", 1'b0, "none", $sformatf("DReadyM c%0d", dq[0].cyc));
            void'(dq.pop_front());
        end
        while (sq.size() > 0) begin
            chk("stall_leftover", 1'b0, "none", $sformatf("stall c%0d", sq[0].cyc));
            void'(sq.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
